hevc_epb_packer: RTL and testbench

HEVC_EPB_PACKER -- requirements
Module: hevc_epb_packer

---
 rtl/hevc_epb_packer_pkg.sv | 20 ++
 rtl/hevc_epb_packer.sv | 107 ++++++++++
 tb/tb_hevc_epb_packer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hevc_epb_packer_pkg.sv
// hevc_epb_packer_pkg: shared state encoding, constants and zero-run helper
// for the HEVC emulation-prevention byte packer.
package hevc_epb_packer_pkg;

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_EPB  = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [7:0]  EPB_BYTE      = 8'h03;
    localparam int unsigned PAD_ALIGN_DEF = 64;

    // Length of the run of payload zeros ending at the byte just emitted, capped at 2.
    function automatic logic [1:0] zero_next(input logic [1:0] zc, input logic [7:0] dat, input logic epb);
        return (epb && dat == 8'h00) ? ((zc == 2'd2) ? 2'd2 : zc + 2'd1) : 2'd0;
    endfunction

endpackage

// File: rtl/hevc_epb_packer.sv
// hevc_epb_packer: inserts 0x03 emulation-prevention bytes into NAL payload
// and zero-pads the output to PAD_ALIGN bytes on flush.
module hevc_epb_packer
    import hevc_epb_packer_pkg::*;
#(
    parameter int unsigned PAD_ALIGN = PAD_ALIGN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bs_val_i,
    input  logic [7:0]  bs_dat_i,
    input  logic        bs_epb_i,
    output logic        bs_rdy_o,
    input  logic        flush_i,
    output logic [7:0]  dout_o,
    output logic        wr_en_o,
    output logic        flush_done_o,
    output logic [31:0] out_cnt_o,
    output logic [15:0] epb_cnt_o
);

    localparam logic [31:0] ALIGN_MASK = 32'(PAD_ALIGN - 1);

    state_e      state_q, state_d;
    logic [7:0]  dout_q, hold_q;
    logic        wr_en_q, done_q, rdy_q, pend_q, rearm_q;
    logic [31:0] out_cnt_q;
    logic [15:0] epb_cnt_q;
    logic [1:0]  zero_cnt_q;

    logic        accept, insert, idle_flush, going_done;
    logic [31:0] cnt_eff, cnt_pad;

    // out_cnt_q lags wr_en_o by a cycle; cnt_eff includes the byte currently on dout_o.
    assign cnt_eff    = out_cnt_q + {31'd0, wr_en_q};
    assign cnt_pad    = cnt_eff + 32'd1;
    assign accept     = bs_val_i && rdy_q;
    assign insert     = accept && bs_epb_i && zero_cnt_q == 2'd2 && bs_dat_i <= EPB_BYTE;
    assign idle_flush = state_q == ST_PASS && !accept && pend_q;
    assign going_done = (idle_flush && (cnt_eff & ALIGN_MASK) == 32'd0) ||
                        (state_q == ST_PAD && (cnt_pad & ALIGN_MASK) == 32'd0);

    always_comb begin
        state_d = (state_q == ST_PASS) ? (insert ? ST_EPB : idle_flush ? (going_done ? ST_DONE : ST_PAD) : ST_PASS)
                : (state_q == ST_PAD)  ? (going_done ? ST_DONE : ST_PAD)
                :                        ST_PASS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PASS;
            dout_q     <= 8'h00;
            hold_q     <= 8'h00;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b0;
            pend_q     <= 1'b0;
            rearm_q    <= 1'b0;
            out_cnt_q  <= 32'd0;
            epb_cnt_q  <= 16'd0;
            zero_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= state_d == ST_PASS;
            done_q    <= going_done;
            wr_en_q   <= 1'b0;
            out_cnt_q <= cnt_eff;
            // A flush arriving while one is already pending is parked in rearm_q and re-armed at DONE.
            pend_q    <= going_done ? (rearm_q || flush_i) : (pend_q || flush_i);
            rearm_q   <= !going_done && (rearm_q || (flush_i && pend_q));
            case (state_q)
                ST_PASS: begin
                    if (accept) begin
                        wr_en_q <= 1'b1;
                        if (insert) begin
                            dout_q     <= EPB_BYTE;
                            hold_q     <= bs_dat_i;
                            zero_cnt_q <= 2'd0;
                            epb_cnt_q  <= (epb_cnt_q == 16'hFFFF) ? epb_cnt_q : epb_cnt_q + 16'd1;
                        end else begin
                            dout_q     <= bs_dat_i;
                            zero_cnt_q <= zero_next(zero_cnt_q, bs_dat_i, bs_epb_i);
                        end
                    end
                end
                ST_EPB: begin
                    wr_en_q    <= 1'b1;
                    dout_q     <= hold_q;
                    zero_cnt_q <= zero_next(zero_cnt_q, hold_q, 1'b1);
                end
                ST_PAD: begin
                    wr_en_q <= 1'b1;
                    dout_q  <= 8'h00;
                end
                default: zero_cnt_q <= 2'd0;
            endcase
        end
    end

    assign bs_rdy_o     = rdy_q;
    assign dout_o       = dout_q;
    assign wr_en_o      = wr_en_q;
    assign flush_done_o = done_q;
    assign out_cnt_o    = out_cnt_q;
    assign epb_cnt_o    = epb_cnt_q;

endmodule

// File: tb/tb_hevc_epb_packer.sv
// tb_hevc_epb_packer: directed and random stimulus checked against a
// byte-queue reference model of emulation prevention and flush padding.
module tb_hevc_epb_packer;

    localparam int ALIGN = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        bs_val_i = 1'b0;
    logic [7:0]  bs_dat_i = 8'h00;
    logic        bs_epb_i = 1'b0;
    logic        bs_rdy_o;
    logic        flush_i = 1'b0;
    logic [7:0]  dout_o;
    logic        wr_en_o;
    logic        flush_done_o;
    logic [31:0] out_cnt_o;
    logic [15:0] epb_cnt_o;

    hevc_epb_packer #(.PAD_ALIGN(ALIGN)) dut (
        .clk(clk), .rst_n(rst_n),
        .bs_val_i(bs_val_i), .bs_dat_i(bs_dat_i), .bs_epb_i(bs_epb_i), .bs_rdy_o(bs_rdy_o),
        .flush_i(flush_i), .dout_o(dout_o), .wr_en_o(wr_en_o), .flush_done_o(flush_done_o),
        .out_cnt_o(out_cnt_o), .epb_cnt_o(epb_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int unsigned m_total = 0;
    int          m_zc = 0;
    int unsigned m_epbs = 0;
    int          done_cnt = 0;
    int          rdy_low = 0;

    always @(negedge clk) begin
        if (rst_n && wr_en_o) got.push_back(dout_o);
        if (rst_n && flush_done_o) done_cnt++;
        if (rst_n && !bs_rdy_o) rdy_low++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void m_push(input logic [7:0] b);
        exp_q.push_back(b);
        m_total++;
    endfunction

    function automatic void m_byte(input logic [7:0] b, input logic e);
        if (e && m_zc == 2 && b <= 8'h03) begin
            m_push(8'h03);
            if (m_epbs < 32'hFFFF) m_epbs++;
            m_zc = 0;
        end
        m_push(b);
        m_zc = (e && b == 8'h00) ? ((m_zc == 2) ? 2 : m_zc + 1) : 0;
    endfunction

    function automatic void m_flush();
        while (m_total % ALIGN != 0) m_push(8'h00);
        m_zc = 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic e, input logic f);
        int n = 0;
        bs_dat_i = b;
        bs_epb_i = e;
        bs_val_i = 1'b1;
        while (!bs_rdy_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("send_rdy", {31'd0, bs_rdy_o}, 32'd1);
        flush_i = f;
        @(negedge clk);
        bs_val_i = 1'b0;
        flush_i = 1'b0;
        m_byte(b, e);
        if (f) m_flush();
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        m_flush();
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!flush_done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, flush_done_o}, 32'd1);
        idle(3);
    endtask

    task automatic compare_out(input string tag);
        int m;
        chk({tag, "_len"}, got.size(), exp_q.size());
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk(tag, {i[23:0], got[i]}, {i[23:0], exp_q[i]});
        got.delete();
        exp_q.delete();
    endtask

    task automatic send_list(input logic [7:0] bytes[$], input logic e);
        foreach (bytes[i]) send(bytes[i], e, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0, r0, base;
        logic [7:0] seq[$];
        logic [7:0] b;
        logic e, f;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("rst_dout", {24'd0, dout_o}, 32'd0);
        chk("rst_done", {31'd0, flush_done_o}, 32'd0);
        chk("rst_rdy", {31'd0, bs_rdy_o}, 32'd0);
        chk("rst_out_cnt", out_cnt_o, 32'd0);
        chk("rst_epb_cnt", {16'd0, epb_cnt_o}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {31'd0, bs_rdy_o}, 32'd1);

        d0 = done_cnt;
        for (int i = 0; i < 10; i++) send(8'($urandom_range(1, 255)), 1'b0, 1'b0);
        do_flush();
        wait_done("pad10_done", lat);
        chk("pad10_out_cnt", out_cnt_o, 32'd64);
        chk("pad10_done_pulses", done_cnt - d0, 32'd1);
        compare_out("pad10_data");

        r0 = rdy_low;
        seq = '{8'h00, 8'h00, 8'h01};
        send_list(seq, 1'b1);
        idle(3);
        chk("epb001_rdy_low", rdy_low - r0, 32'd1);
        chk("epb001_epb_cnt", {16'd0, epb_cnt_o}, 32'd1);
        compare_out("epb001_data");
        do_flush();
        wait_done("epb001_done", lat);
        compare_out("epb001_pad");

        seq = '{8'h00, 8'h00, 8'h00, 8'h01};
        send_list(seq, 1'b0);
        idle(3);
        chk("start_code_epb_cnt", {16'd0, epb_cnt_o}, 32'd1);
        compare_out("start_code_data");
        do_flush();
        wait_done("start_code_done", lat);
        compare_out("start_code_pad");

        seq = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h03};
        send_list(seq, 1'b1);
        idle(3);
        chk("epb_03_epb_cnt", {16'd0, epb_cnt_o}, 32'd2);
        chk("epb_03_len", got.size(), 32'd7);
        compare_out("epb_03_data");
        do_flush();
        wait_done("epb_03_done", lat);
        compare_out("epb_03_pad");

        base = out_cnt_o;
        d0 = done_cnt;
        for (int i = 0; i < 128; i++) send(8'($urandom), 1'b0, 1'b0);
        do_flush();
        wait_done("full128_done", lat);
        chk("full128_latency", {31'd0, lat <= 1}, 32'd1);
        chk("full128_out_cnt", out_cnt_o, base + 32'd128);
        chk("full128_done_pulses", done_cnt - d0, 32'd1);
        compare_out("full128_data");

        for (int i = 0; i < 400; i++) begin
            b = ($urandom_range(0, 7) < 4) ? 8'h00 : ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            e = $urandom_range(0, 7) != 0;
            f = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 9) == 0) idle(1);
            send(b, e, f);
            if (f) wait_done("rand_flush_byte_done", lat);
            if ($urandom_range(0, 49) == 0) begin
                do_flush();
                wait_done("rand_flush_done", lat);
            end
        end
        do_flush();
        wait_done("rand_final_done", lat);
        chk("rand_out_cnt", out_cnt_o, m_total);
        chk("rand_epb_cnt", {16'd0, epb_cnt_o}, m_epbs);
        chk("rand_aligned", out_cnt_o % ALIGN, 32'd0);
        compare_out("rand_data");

        for (int i = 0; i < 5; i++) send(8'($urandom_range(1, 255)), 1'b0, 1'b0);
        do_flush();
        base = got.size();
        lat = 0;
        while (got.size() < base + 20 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("midpad_reached", {31'd0, got.size() >= base + 20}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midpad_rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("midpad_rst_out_cnt", out_cnt_o, 32'd0);
        chk("midpad_rst_rdy", {31'd0, bs_rdy_o}, 32'd0);
        base = got.size();
        idle(2);
        chk("midpad_no_output", got.size(), base);
        rst_n = 1'b1;
        got.delete();
        exp_q.delete();
        m_total = 0;
        m_zc = 0;
        m_epbs = 0;
        @(negedge clk);
        chk("midpad_rdy_after", {31'd0, bs_rdy_o}, 32'd1);
        seq = '{8'h00, 8'h00, 8'h01};
        send_list(seq, 1'b1);
        do_flush();
        wait_done("post_rst_done", lat);
        chk("post_rst_out_cnt", out_cnt_o, 32'd64);
        chk("post_rst_epb_cnt", {16'd0, epb_cnt_o}, 32'd1);
        compare_out("post_rst_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
